// File: rtl/dcache_2way_wb.sv
// dcache_2way_wb: 2-way set-associative write-back write-allocate data cache with a word-serial memory port
module dcache_2way_wb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int NUM_SETS = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} state_t;
  state_t state, nxt;
  logic [OFF_W-1:0] cnt, cnt_n, off;
  logic [IDX_W-1:0] idx, idx_q, idx_n;
  logic [TAG_W-1:0] tag, vtag_q, vtag_n, rtag_q, rtag_n;
  logic [1:0] unused_lo;
  logic way_q, way_n, hit0, hit1, hit, req, victim, ack, last, acc_hit, miss, xfer_n;
  logic [TAG_W-1:0] tag_a [2][NUM_SETS];
  logic [DATA_W-1:0] data_a [2][NUM_SETS][WORDS_PER_LINE];
  logic [1:0][NUM_SETS-1:0] vld, dty;
  logic [NUM_SETS-1:0] lru;
  assign {tag, idx, off, unused_lo} = cpu_addr;
  assign req = cpu_rd | cpu_wr;
  assign hit0 = vld[1'b0][idx] && tag_a[1'b0][idx] == tag;
  assign hit1 = vld[1'b1][idx] && tag_a[1'b1][idx] == tag;
  assign hit = hit0 | hit1;
  assign victim = !vld[1'b0][idx] ? 1'b0 : !vld[1'b1][idx] ? 1'b1 : lru[idx];
  assign ack = mem_req & mem_ack;
  assign last = &cnt;
  assign acc_hit = state == IDLE && req && hit;
  assign miss = state == IDLE && req && !hit;
  assign xfer_n = nxt == WB || nxt == REFILL;
  always_comb begin
    nxt = state;
    cnt_n = cnt;
    way_n = way_q;
    idx_n = idx_q;
    vtag_n = vtag_q;
    rtag_n = rtag_q;
    stall = state != IDLE || (req && !hit);
    cpu_rdata = (state == IDLE && cpu_rd && !cpu_wr && hit) ? data_a[hit1][idx][off] : '0;
    if (miss) begin
      way_n = victim;
      idx_n = idx;
      vtag_n = tag_a[victim][idx];
      rtag_n = tag;
      nxt = (vld[victim][idx] && dty[victim][idx]) ? WB : REFILL;
    end
    if ((state == WB || state == REFILL) && ack) begin
      cnt_n = cnt + 1'b1;
      if (last) nxt = state == WB ? REFILL : DONE;
    end
    if (state == DONE) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      way_q <= 1'b0;
      idx_q <= '0;
      vtag_q <= '0;
      rtag_q <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      way_q <= way_n;
      idx_q <= idx_n;
      vtag_q <= vtag_n;
      rtag_q <= rtag_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      dty <= '0;
      lru <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req <= xfer_n;
      mem_we <= nxt == WB;
      mem_addr <= xfer_n ? {nxt == WB ? vtag_n : rtag_n, idx_n, cnt_n, 2'b00} : '0;
      mem_wdata <= nxt == WB ? data_a[way_n][idx_n][cnt_n] : '0;
      if (acc_hit) begin
        lru[idx] <= !hit1;
        if (cpu_wr) dty[hit1][idx] <= 1'b1;
      end
      if (state == REFILL && ack && last) begin
        vld[way_q][idx_q] <= 1'b1;
        dty[way_q][idx_q] <= 1'b0;
        lru[idx_q] <= !way_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (acc_hit && cpu_wr) data_a[hit1][idx][off] <= cpu_wdata;
    if (state == REFILL && ack) data_a[way_q][idx_q][cnt] <= mem_rdata;
    if (state == REFILL && ack && last) tag_a[way_q][idx_q] <= rtag_q;
  end
endmodule
